ysyx_22040386_wb_retire: RTL and testbench



---
 rtl/ysyx_22040386_wb_pkg.sv | 14 +
 rtl/ysyx_22040386_wb_retire_if.sv | 35 +++
 rtl/ysyx_22040386_wb_fifo.sv | 47 ++++
 rtl/ysyx_22040386_wb_retire.sv | 114 +++++++++++
 tb/tb_ysyx_22040386_wb_retire.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040386_wb_pkg.sv
// Shared types for the writeback/retire stage: retire entry layout and grant sources.
package ysyx_22040386_wb_pkg;
  localparam int WB_XLEN = 64;
  localparam int WB_AW   = 5;

  typedef struct packed {
    logic [WB_XLEN-1:0] pc;
    logic [WB_XLEN-1:0] data;
    logic [WB_AW-1:0]   addr;
    logic               we;
  } wb_entry_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_LL, GNT_FIFO, GNT_BYP} gnt_e;
endpackage

// File: rtl/ysyx_22040386_wb_retire_if.sv
// Retire-stage bus: MEM/WB input handshake, long-latency result port and writeback outputs.
interface ysyx_22040386_wb_retire_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            i_WB_valid;
  logic            o_WB_ready;
  logic [XLEN-1:0] i_WB_reg_wr_data;
  logic            i_WB_RegWrite;
  logic [AW-1:0]   i_WB_reg_wr_addr;
  logic [XLEN-1:0] i_WB_pc;
  logic            i_LL_valid;
  logic            o_LL_ready;
  logic [AW-1:0]   i_LL_addr;
  logic [XLEN-1:0] i_LL_data;
  logic            o_WB_RegWrite;
  logic [AW-1:0]   o_WB_reg_wr_addr;
  logic [XLEN-1:0] o_WB_reg_wr_data;
  logic [XLEN-1:0] o_WB_pc;
  logic            o_WB_commit;

  modport master (
    output i_WB_valid, i_WB_reg_wr_data, i_WB_RegWrite, i_WB_reg_wr_addr, i_WB_pc,
    output i_LL_valid, i_LL_addr, i_LL_data,
    input  o_WB_ready, o_LL_ready, o_WB_RegWrite, o_WB_reg_wr_addr, o_WB_reg_wr_data,
    input  o_WB_pc, o_WB_commit
  );

  modport slave (
    input  i_WB_valid, i_WB_reg_wr_data, i_WB_RegWrite, i_WB_reg_wr_addr, i_WB_pc,
    input  i_LL_valid, i_LL_addr, i_LL_data,
    output o_WB_ready, o_LL_ready, o_WB_RegWrite, o_WB_reg_wr_addr, o_WB_reg_wr_data,
    output o_WB_pc, o_WB_commit
  );
endinterface

// File: rtl/ysyx_22040386_wb_fifo.sv
// In-order retire FIFO; pointer reset alone discards contents, storage itself is not reset.
module ysyx_22040386_wb_fifo
  import ysyx_22040386_wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = DEPTH[PW:0];

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
endmodule

// File: rtl/ysyx_22040386_wb_retire.sv
// Writeback/retire stage: arbitrates the regfile write port between LL results, the FIFO and bypass.
// Define YSYX_WB_COMMIT_CNT_EN to add the 64-bit o_WB_commit_cnt retire counter.
module ysyx_22040386_wb_retire
  import ysyx_22040386_wb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
`ifdef YSYX_WB_COMMIT_CNT_EN
  output logic [63:0]                   o_WB_commit_cnt,
`endif
  ysyx_22040386_wb_retire_if.slave      wb
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic [AW-1:0]   addr;
    logic            we;
  } entry_t;

  entry_t        in_entry, head, sel;
  logic          fifo_full, fifo_empty;
  logic          accept, starve, push, pop;
  logic [SW-1:0] starve_cnt;
  gnt_e          gnt;

  always_comb begin
    in_entry      = '0;
    in_entry.pc   = wb.i_WB_pc;
    in_entry.data = wb.i_WB_reg_wr_data;
    in_entry.addr = wb.i_WB_reg_wr_addr;
    in_entry.we   = wb.i_WB_RegWrite;
  end

  // Ready looks only at registered occupancy, so no path from i_WB_valid.
  assign wb.o_WB_ready = i_rst_n & ~fifo_full;
  assign accept        = wb.i_WB_valid & wb.o_WB_ready;
  assign starve        = ~fifo_empty & (starve_cnt == STARVE_LIM);
  assign wb.o_LL_ready = wb.i_LL_valid & ~starve;

  always_comb begin
    gnt = GNT_NONE;
    if (wb.o_LL_ready)    gnt = GNT_LL;
    else if (!fifo_empty) gnt = GNT_FIFO;
    else if (accept)      gnt = GNT_BYP;
  end

  assign push = accept & (gnt != GNT_BYP);
  assign pop  = (gnt == GNT_FIFO);
  assign sel  = (gnt == GNT_FIFO) ? head : in_entry;

  ysyx_22040386_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .din     (in_entry),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The counter only advances while something is waiting behind the LL unit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   starve_cnt <= '0;
    else if (gnt == GNT_LL && !fifo_empty)          starve_cnt <= starve_cnt + 1'b1;
    else if (gnt == GNT_FIFO || gnt == GNT_BYP)     starve_cnt <= '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb.o_WB_RegWrite    <= 1'b0;
      wb.o_WB_reg_wr_addr <= '0;
      wb.o_WB_reg_wr_data <= '0;
      wb.o_WB_pc          <= '0;
      wb.o_WB_commit      <= 1'b0;
    end else begin
      wb.o_WB_RegWrite <= 1'b0;
      wb.o_WB_commit   <= 1'b0;
      case (gnt)
        GNT_LL: begin
          wb.o_WB_RegWrite    <= |wb.i_LL_addr;
          wb.o_WB_reg_wr_addr <= wb.i_LL_addr;
          wb.o_WB_reg_wr_data <= wb.i_LL_data;
        end
        GNT_FIFO, GNT_BYP: begin
          wb.o_WB_RegWrite    <= sel.we & (|sel.addr);
          wb.o_WB_reg_wr_addr <= sel.addr;
          wb.o_WB_reg_wr_data <= sel.data;
          wb.o_WB_pc          <= sel.pc;
          wb.o_WB_commit      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef YSYX_WB_COMMIT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_WB_commit_cnt <= '0;
    else          o_WB_commit_cnt <= o_WB_commit_cnt + 64'(wb.o_WB_commit);
  end
`endif
endmodule

// File: tb/tb_ysyx_22040386_wb_retire.sv
// Directed bench for the retire stage: reset, x0, LL starvation, back-to-back, mid-stream reset, contention.
module tb_ysyx_22040386_wb_retire;
  logic i_clk, i_rst_n;
  int   n_cmp = 0, n_err = 0;

  ysyx_22040386_wb_retire_if #(.XLEN(64), .AW(5)) w ();
`ifdef YSYX_WB_COMMIT_CNT_EN
  logic [63:0] commit_cnt;
`endif

  ysyx_22040386_wb_retire #(.XLEN(64), .AW(5), .DEPTH(2), .STARVE_MAX(4)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
`ifdef YSYX_WB_COMMIT_CNT_EN
    .o_WB_commit_cnt (commit_cnt),
`endif
    .wb              (w)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb_drive(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                          input logic [63:0] data, input logic we);
    w.i_WB_valid = v; w.i_WB_pc = pc; w.i_WB_reg_wr_addr = rd;
    w.i_WB_reg_wr_data = data; w.i_WB_RegWrite = we;
  endtask

  task automatic ll_drive(input logic v, input logic [4:0] rd, input logic [63:0] data);
    w.i_LL_valid = v; w.i_LL_addr = rd; w.i_LL_data = data;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] rd,
                         input logic [63:0] data, input logic [63:0] pc, input logic commit);
    chk({tag, ".we"},     {63'd0, w.o_WB_RegWrite}, {63'd0, we});
    chk({tag, ".addr"},   {59'd0, w.o_WB_reg_wr_addr}, {59'd0, rd});
    chk({tag, ".data"},   w.o_WB_reg_wr_data, data);
    chk({tag, ".pc"},     w.o_WB_pc, pc);
    chk({tag, ".commit"}, {63'd0, w.o_WB_commit}, {63'd0, commit});
  endtask

  // LL contention scenario, cycles c0..c12 (STARVE_MAX=4, DEPTH=2), worked out by hand.
  bit          e_llr [13] = '{1,1,1,1,1,0,1,1,1,1,0,0,0};
  bit          e_rdy [13] = '{1,1,0,0,0,0,1,0,0,0,0,1,1};
  bit          e_cmt [13] = '{0,0,0,0,0,1,0,0,0,0,1,1,0};
  bit          e_we  [13] = '{1,1,1,1,1,1,1,1,1,1,1,1,0};
  logic [4:0]  e_rd  [13] = '{7,7,7,7,7,10,7,7,7,7,11,12,12};
  logic [63:0] e_dat [13] = '{64'hD000,64'hD001,64'hD002,64'hD003,64'hD004,64'hA1,
                              64'hD006,64'hD007,64'hD008,64'hD009,64'hA2,64'hA3,64'hA3};
  logic [63:0] e_pc  [13] = '{64'h80000008,64'h80000008,64'h80000008,64'h80000008,64'h80000008,
                              64'h100,64'h100,64'h100,64'h100,64'h100,64'h104,64'h108,64'h108};

  initial begin
    i_rst_n = 1'b0;
    wb_drive(0, 0, 0, 0, 0);
    ll_drive(0, 0, 0);
    #12;
    chk("rst.ready", {63'd0, w.o_WB_ready}, 64'd0);
    chk_out("rst", 0, 0, 0, 0, 0);

    // Single retire through the bypass path
    step();
    i_rst_n = 1'b1;
    wb_drive(1, 64'h8000_0000, 5, 64'h1234, 1);
    #1 chk("t1.ready", {63'd0, w.o_WB_ready}, 64'd1);
    step();
    wb_drive(0, 0, 0, 0, 0);
    chk_out("t1", 1, 5, 64'h1234, 64'h8000_0000, 1);
    chk("t1.ready_after", {63'd0, w.o_WB_ready}, 64'd1);
    step();
    chk_out("t1.idle", 0, 5, 64'h1234, 64'h8000_0000, 0);

    // x0 write and RegWrite=0 both commit without a regfile write
    wb_drive(1, 64'h8000_0004, 0, 64'hFFFF, 1);
    step();
    chk_out("t2.x0", 0, 0, 64'hFFFF, 64'h8000_0004, 1);
    wb_drive(1, 64'h8000_0008, 6, 64'hAB, 0);
    step();
    wb_drive(0, 0, 0, 0, 0);
    chk_out("t2.nowe", 0, 6, 64'hAB, 64'h8000_0008, 1);

    // LL streams for 10 cycles while three retires arrive
    for (int c = 0; c < 13; c++) begin
      ll_drive(c < 10, 7, 64'hD000 + 64'(c));
      if (c == 0)      wb_drive(1, 64'h100, 10, 64'hA1, 1);
      else if (c == 1) wb_drive(1, 64'h104, 11, 64'hA2, 1);
      else if (c <= 6) wb_drive(1, 64'h108, 12, 64'hA3, 1);
      else             wb_drive(0, 0, 0, 0, 0);
      #2;
      chk($sformatf("t3.c%0d.ll_ready", c), {63'd0, w.o_LL_ready}, {63'd0, e_llr[c]});
      chk($sformatf("t3.c%0d.wb_ready", c), {63'd0, w.o_WB_ready}, {63'd0, e_rdy[c]});
      step();
      chk_out($sformatf("t3.c%0d", c), e_we[c], e_rd[c], e_dat[c], e_pc[c], e_cmt[c]);
    end
    ll_drive(0, 0, 0);

    // Fresh reset, then 20 back-to-back retires
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wb_drive(1, 64'h2000 + 64'(4 * i), 5'((i % 31) + 1), 64'(3 * i + 1), 1);
      #2 chk($sformatf("t4.i%0d.ready", i), {63'd0, w.o_WB_ready}, 64'd1);
      step();
      chk_out($sformatf("t4.i%0d", i), 1, 5'((i % 31) + 1), 64'(3 * i + 1),
              64'h2000 + 64'(4 * i), 1);
    end
    wb_drive(0, 0, 0, 0, 0);
    step();
    chk("t4.drain.commit", {63'd0, w.o_WB_commit}, 64'd0);
`ifdef YSYX_WB_COMMIT_CNT_EN
    chk("t4.commit_cnt", commit_cnt, 64'd20);
`endif

    // Fill the FIFO behind LL traffic, then reset mid-cycle
    ll_drive(1, 7, 64'hEE);
    wb_drive(1, 64'h4000, 4, 64'h44, 1);
    step();
    wb_drive(1, 64'h4004, 5, 64'h55, 1);
    step();
    #1 chk("t5.full.ready", {63'd0, w.o_WB_ready}, 64'd0);
    chk("t5.full.data", w.o_WB_reg_wr_data, 64'hEE);
    #1 i_rst_n = 1'b0;
    #1;
    chk("t5.rst.ready", {63'd0, w.o_WB_ready}, 64'd0);
    chk_out("t5.rst", 0, 0, 0, 0, 0);
    wb_drive(0, 0, 0, 0, 0);
    ll_drive(0, 0, 0);
    step();
    i_rst_n = 1'b1;
    #1 chk("t5.rel.ready", {63'd0, w.o_WB_ready}, 64'd1);
    step();
    chk_out("t5.rel1", 0, 0, 0, 0, 0);
    step();
    chk_out("t5.rel2", 0, 0, 0, 0, 0);

    // LL and bypass contend with the FIFO empty
    ll_drive(1, 9, 64'h55);
    wb_drive(1, 64'h3000, 3, 64'h77, 1);
    #2 chk("t6.ll_ready", {63'd0, w.o_LL_ready}, 64'd1);
    step();
    ll_drive(0, 0, 0);
    wb_drive(0, 0, 0, 0, 0);
    chk_out("t6.ll", 1, 9, 64'h55, 0, 0);
    step();
    chk_out("t6.fifo", 1, 3, 64'h77, 64'h3000, 1);
    ll_drive(1, 0, 64'h99);
    #2 chk("t6.llx0.ready", {63'd0, w.o_LL_ready}, 64'd1);
    step();
    ll_drive(0, 0, 0);
    chk_out("t6.llx0", 0, 0, 64'h99, 64'h3000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
